// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared pipeline definitions for the forwarding/hazard controller:
// operand-select codes and the shadow-slot record.
package fwd_hazard_ctrl_pkg;

   // Slot rd fields are sized for the widest supported register address.
   // Narrower addresses are zero-extended on entry.
   localparam int RD_MAX_W = 8;

   typedef logic [1:0]          fwd_sel_t;
   typedef logic [RD_MAX_W-1:0] reg_addr_t;

   localparam fwd_sel_t FWD_RF  = 2'b00;
   localparam fwd_sel_t FWD_MEM = 2'b01;
   localparam fwd_sel_t FWD_WB  = 2'b10;

   typedef struct packed {
      logic      valid;
      reg_addr_t rd;
      logic      reg_write;
      logic      mem_read;
   } slot_t;

   // True when the slot produces a forwardable result for register r (never x0).
   function automatic logic slot_writes(input slot_t s, input reg_addr_t r);
      return s.valid && s.reg_write && (s.rd != '0) && (s.rd == r);
   endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_sel.sv
// Combinational forwarding select for one EX operand.
// The MEM result is newer than the WB result, so MEM wins when both match.
module fwd_sel_unit
   import fwd_hazard_ctrl_pkg::*;
(
   input  slot_t     mem_slot,
   input  slot_t     wb_slot,
   input  reg_addr_t src,
   input  logic      use_src,
   output fwd_sel_t  sel
);

   always_comb begin
      sel = FWD_RF;
      if (use_src) begin
         if (slot_writes(mem_slot, src)) begin
            sel = FWD_MEM;
         end else if (slot_writes(wb_slot, src)) begin
            sel = FWD_WB;
         end
      end
   end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard controller: shadow EX/MEM/WB slots, operand forwarding
// selects, load-use stall/bubble generation and a saturating stall counter.
module fwd_hazard_ctrl
   import fwd_hazard_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  arst,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_use_rs1,
   input  logic                  id_use_rs2,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  id_reg_write,
   input  logic                  id_mem_read,
   input  logic                  flush,
   input  logic                  cnt_clear,
   output logic [1:0]            fwd_a_sel,
   output logic [1:0]            fwd_b_sel,
   output logic                  stall,
   output logic                  id_ex_bubble,
   output logic [CNT_W-1:0]      stall_cnt
);

   slot_t     ex_slot, mem_slot, wb_slot;
   reg_addr_t ex_rs1, ex_rs2;
   logic      ex_use_rs1, ex_use_rs2;

   reg_addr_t id_rs1_ext, id_rs2_ext, id_rd_ext;
   logic      load_use;

   assign id_rs1_ext = RD_MAX_W'(id_rs1);
   assign id_rs2_ext = RD_MAX_W'(id_rs2);
   assign id_rd_ext  = RD_MAX_W'(id_rd);

   // A load in EX whose rd is consumed by the ID instruction cannot forward in time.
   assign load_use = ex_slot.valid && ex_slot.mem_read && ex_slot.reg_write &&
                     (ex_slot.rd != '0) &&
                     ((id_use_rs1 && (id_rs1_ext == ex_slot.rd)) ||
                      (id_use_rs2 && (id_rs2_ext == ex_slot.rd)));

   // A flushed ID instruction is dead, so it never needs holding.
   assign stall        = load_use && !flush;
   assign id_ex_bubble = stall || flush;

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         ex_slot    <= '0;
         mem_slot   <= '0;
         wb_slot    <= '0;
         ex_rs1     <= '0;
         ex_rs2     <= '0;
         ex_use_rs1 <= 1'b0;
         ex_use_rs2 <= 1'b0;
      end else begin
         wb_slot  <= mem_slot;
         mem_slot <= ex_slot;
         if (id_ex_bubble) begin
            ex_slot    <= '0;
            ex_rs1     <= '0;
            ex_rs2     <= '0;
            ex_use_rs1 <= 1'b0;
            ex_use_rs2 <= 1'b0;
         end else begin
            ex_slot    <= '{valid: 1'b1, rd: id_rd_ext,
                            reg_write: id_reg_write, mem_read: id_mem_read};
            ex_rs1     <= id_rs1_ext;
            ex_rs2     <= id_rs2_ext;
            ex_use_rs1 <= id_use_rs1;
            ex_use_rs2 <= id_use_rs2;
         end
      end
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         stall_cnt <= '0;
      end else if (cnt_clear) begin
         stall_cnt <= '0;
      end else if (stall && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

   fwd_sel_unit u_fwd_a (
      .mem_slot (mem_slot),
      .wb_slot  (wb_slot),
      .src      (ex_rs1),
      .use_src  (ex_use_rs1),
      .sel      (fwd_a_sel)
   );

   fwd_sel_unit u_fwd_b (
      .mem_slot (mem_slot),
      .wb_slot  (wb_slot),
      .src      (ex_rs2),
      .use_src  (ex_use_rs2),
      .sel      (fwd_b_sel)
   );

   // The load-use stall must keep a loaded value from ever being taken from EX/MEM.
   assert property (@(posedge clk) disable iff (arst)
      !(mem_slot.valid && mem_slot.mem_read &&
        ((fwd_a_sel == FWD_MEM) || (fwd_b_sel == FWD_MEM))));

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed testbench for fwd_hazard_ctrl with a 2-bit stall counter.
module tb_fwd_hazard_ctrl;

   logic       clk = 1'b0;
   logic       arst;
   logic [4:0] id_rs1, id_rs2, id_rd;
   logic       id_use_rs1, id_use_rs2, id_reg_write, id_mem_read;
   logic       flush, cnt_clear;
   logic [1:0] fwd_a_sel, fwd_b_sel;
   logic       stall, id_ex_bubble;
   logic [1:0] stall_cnt;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fwd_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(2)) dut (
      .clk          (clk),
      .arst         (arst),
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .id_use_rs1   (id_use_rs1),
      .id_use_rs2   (id_use_rs2),
      .id_rd        (id_rd),
      .id_reg_write (id_reg_write),
      .id_mem_read  (id_mem_read),
      .flush        (flush),
      .cnt_clear    (cnt_clear),
      .fwd_a_sel    (fwd_a_sel),
      .fwd_b_sel    (fwd_b_sel),
      .stall        (stall),
      .id_ex_bubble (id_ex_bubble),
      .stall_cnt    (stall_cnt)
   );

   task automatic set_id(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                         input logic u2, input logic [4:0] rd, input logic rw, input logic mr);
      id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
      id_rd = rd; id_reg_write = rw; id_mem_read = mr; flush = 1'b0;
   endtask

   task automatic set_nop();
      set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      set_nop();
      repeat (3) tick();
   endtask

   task automatic clear_cnt();
      cnt_clear = 1'b1;
      tick();
      cnt_clear = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      checks++; if (fwd_a_sel !== 2'b00) begin failures++; $display("FAIL rst_fwd_a actual=%b expected=00", fwd_a_sel); end
      checks++; if (fwd_b_sel !== 2'b00) begin failures++; $display("FAIL rst_fwd_b actual=%b expected=00", fwd_b_sel); end
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rst_stall actual=%b expected=0", stall); end
      checks++; if (id_ex_bubble !== 1'b0) begin failures++; $display("FAIL rst_bubble actual=%b expected=0", id_ex_bubble); end
      checks++; if (stall_cnt !== 2'd0) begin failures++; $display("FAIL rst_cnt actual=%0d expected=0", stall_cnt); end
      @(negedge clk);
      arst = 1'b0;
      $display("reset released, outputs idle");
   endtask

   task automatic test_raw_dist1();
      drain();
      set_id(5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);   // add x5, x1, x2
      tick();
      set_id(5'd5, 1'b1, 5'd3, 1'b1, 5'd6, 1'b1, 1'b0);   // sub x6, x5, x3
      #1;
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL d1_stall actual=%b expected=0", stall); end
      tick();
      set_nop();
      #1;
      checks++; if (fwd_a_sel !== 2'b01) begin failures++; $display("FAIL d1_fwd_a actual=%b expected=01", fwd_a_sel); end
      checks++; if (fwd_b_sel !== 2'b00) begin failures++; $display("FAIL d1_fwd_b actual=%b expected=00", fwd_b_sel); end
      $display("raw distance 1: fwd_a=%b fwd_b=%b", fwd_a_sel, fwd_b_sel);
   endtask

   task automatic test_raw_dist2();
      drain();
      set_id(5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);   // add x5
      tick();
      set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);   // writes x9
      tick();
      set_id(5'd1, 1'b1, 5'd5, 1'b1, 5'd10, 1'b1, 1'b0);  // reads x1, x5
      tick();
      set_nop();
      #1;
      checks++; if (fwd_b_sel !== 2'b10) begin failures++; $display("FAIL d2_fwd_b actual=%b expected=10", fwd_b_sel); end
      checks++; if (fwd_a_sel !== 2'b00) begin failures++; $display("FAIL d2_fwd_a actual=%b expected=00", fwd_a_sel); end
      $display("raw distance 2: fwd_b=%b", fwd_b_sel);
      drain();
      set_id(5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);   // add x5
      tick();
      set_id(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);   // addi x5, x5
      tick();
      set_id(5'd5, 1'b1, 5'd5, 1'b1, 5'd11, 1'b1, 1'b0);  // reads x5 twice
      tick();
      set_nop();
      #1;
      checks++; if (fwd_b_sel !== 2'b01) begin failures++; $display("FAIL dbl_fwd_b actual=%b expected=01", fwd_b_sel); end
      checks++; if (fwd_a_sel !== 2'b01) begin failures++; $display("FAIL dbl_fwd_a actual=%b expected=01", fwd_a_sel); end
      $display("double match: fwd_a=%b fwd_b=%b", fwd_a_sel, fwd_b_sel);
   endtask

   task automatic test_load_use();
      drain();
      clear_cnt();
      checks++; if (stall_cnt !== 2'd0) begin failures++; $display("FAIL lu_cnt0 actual=%0d expected=0", stall_cnt); end
      set_id(5'd2, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);   // lw x7
      #1;
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL lu_pre_stall actual=%b expected=0", stall); end
      tick();
      set_id(5'd1, 1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0);   // add x8, x1, x7
      #1;
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL lu_stall actual=%b expected=1", stall); end
      checks++; if (id_ex_bubble !== 1'b1) begin failures++; $display("FAIL lu_bubble actual=%b expected=1", id_ex_bubble); end
      tick();                                              // ID held
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL lu_stall2 actual=%b expected=0", stall); end
      checks++; if (id_ex_bubble !== 1'b0) begin failures++; $display("FAIL lu_bubble2 actual=%b expected=0", id_ex_bubble); end
      checks++; if (stall_cnt !== 2'd1) begin failures++; $display("FAIL lu_cnt actual=%0d expected=1", stall_cnt); end
      tick();
      set_nop();
      #1;
      checks++; if (fwd_b_sel !== 2'b10) begin failures++; $display("FAIL lu_fwd_b actual=%b expected=10", fwd_b_sel); end
      checks++; if (fwd_a_sel !== 2'b00) begin failures++; $display("FAIL lu_fwd_a actual=%b expected=00", fwd_a_sel); end
      $display("load-use: stall_cnt=%0d fwd_b=%b", stall_cnt, fwd_b_sel);
   endtask

   task automatic test_x0_unused();
      drain();
      set_id(5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);   // addi x0
      tick();
      set_id(5'd0, 1'b1, 5'd0, 1'b1, 5'd12, 1'b1, 1'b0);  // reads x0, x0
      tick();
      set_nop();
      #1;
      checks++; if (fwd_a_sel !== 2'b00) begin failures++; $display("FAIL x0_fwd_a actual=%b expected=00", fwd_a_sel); end
      checks++; if (fwd_b_sel !== 2'b00) begin failures++; $display("FAIL x0_fwd_b actual=%b expected=00", fwd_b_sel); end
      drain();
      set_id(5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);   // add x5
      tick();
      set_id(5'd3, 1'b1, 5'd5, 1'b0, 5'd13, 1'b1, 1'b0);  // rs2=x5 unused
      tick();
      set_nop();
      #1;
      checks++; if (fwd_b_sel !== 2'b00) begin failures++; $display("FAIL unused_fwd_b actual=%b expected=00", fwd_b_sel); end
      checks++; if (fwd_a_sel !== 2'b00) begin failures++; $display("FAIL unused_fwd_a actual=%b expected=00", fwd_a_sel); end
      $display("x0/unused: fwd_a=%b fwd_b=%b", fwd_a_sel, fwd_b_sel);
   endtask

   task automatic test_flush_load_use();
      drain();
      set_id(5'd2, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);   // lw x7
      tick();
      set_id(5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);   // reader of x7
      flush = 1'b1;
      #1;
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL fl_stall actual=%b expected=0", stall); end
      checks++; if (id_ex_bubble !== 1'b1) begin failures++; $display("FAIL fl_bubble actual=%b expected=1", id_ex_bubble); end
      tick();
      set_nop();
      #1;
      checks++; if (stall_cnt !== 2'd1) begin failures++; $display("FAIL fl_cnt actual=%0d expected=1", stall_cnt); end
      checks++; if (fwd_a_sel !== 2'b00) begin failures++; $display("FAIL fl_fwd_a actual=%b expected=00", fwd_a_sel); end
      $display("flush on load-use: stall_cnt=%0d", stall_cnt);
   endtask

   task automatic test_reset_mid_stall();
      drain();
      set_id(5'd2, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);   // lw x7
      tick();
      set_id(5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
      #1;
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL mrst_pre actual=%b expected=1", stall); end
      arst = 1'b1;
      #1;
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL mrst_stall actual=%b expected=0", stall); end
      checks++; if (id_ex_bubble !== 1'b0) begin failures++; $display("FAIL mrst_bubble actual=%b expected=0", id_ex_bubble); end
      checks++; if (stall_cnt !== 2'd0) begin failures++; $display("FAIL mrst_cnt actual=%0d expected=0", stall_cnt); end
      checks++; if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) begin failures++; $display("FAIL mrst_fwd actual=%b expected=0000", {fwd_a_sel, fwd_b_sel}); end
      @(negedge clk);
      arst = 1'b0;
      $display("reset mid-stall: stall=%b cnt=%0d", stall, stall_cnt);
   endtask

   task automatic test_saturation();
      logic [1:0] exp_cnt;
      drain();
      clear_cnt();
      for (int i = 0; i < 5; i++) begin
         set_id(5'd2, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);   // lw x7
         tick();
         set_id(5'd1, 1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0);   // add using x7
         #1;
         checks++; if (stall !== 1'b1) begin failures++; $display("FAIL sat_stall%0d actual=%b expected=1", i, stall); end
         tick();
         exp_cnt = (i >= 2) ? 2'd3 : 2'(i + 1);
         checks++; if (stall_cnt !== exp_cnt) begin failures++; $display("FAIL sat_cnt%0d actual=%0d expected=%0d", i, stall_cnt, exp_cnt); end
         tick();
         $display("saturation pair %0d: stall_cnt=%0d", i, stall_cnt);
      end
      set_nop();
      clear_cnt();
      checks++; if (stall_cnt !== 2'd0) begin failures++; $display("FAIL clr_cnt actual=%0d expected=0", stall_cnt); end
      drain();
      set_id(5'd2, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
      tick();
      set_id(5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
      cnt_clear = 1'b1;                                      // clear beats increment
      tick();
      cnt_clear = 1'b0;
      checks++; if (stall_cnt !== 2'd0) begin failures++; $display("FAIL clr_prio actual=%0d expected=0", stall_cnt); end
      $display("counter clear: stall_cnt=%0d", stall_cnt);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1);
   end

   initial begin
      arst = 1'b1;
      cnt_clear = 1'b0;
      set_nop();
      test_reset();
      test_raw_dist1();
      test_raw_dist2();
      test_load_use();
      test_x0_unused();
      test_flush_load_use();
      test_reset_mid_stall();
      test_saturation();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fwd_hazard_ctrl.md
# fwd_hazard_ctrl

Forwarding and hazard controller for the 5-stage pipelined core. Keeps a shadow pipeline of destination-register information for the EX, MEM and WB stages. From it, the block generates:
- the 2-bit select codes for the two three-way ALU operand muxes;
- load-use stall and bubble control;
- flush handling;
- a saturating stall-cycle counter for performance monitoring.

## Interface
- `REG_ADDR_W`, default 5: register address width.
- `CNT_W`, default 16: stall counter width.
- `clk`  in  1: clock.
- `arst`  in  1: asynchronous reset, active-high.
- `id_rs1`, `id_rs2`  in  REG_ADDR_W: source registers of the instruction in ID.
- `id_use_rs1`, `id_use_rs2`  in  1: ID instruction actually reads rs1 / rs2.
- `id_rd`  in  REG_ADDR_W: destination register of the ID instruction.
- `id_reg_write`  in  1: ID instruction writes rd.
- `id_mem_read`  in  1: ID instruction is a load.
- `flush`  in  1: taken branch/jump resolved in EX; kill the ID and EX slots.
- `cnt_clear`  in  1: synchronous clear of the stall counter.
- `fwd_a_sel`, `fwd_b_sel`  out  2: operand select for the EX stage. 2'b00 = register file value, 2'b01 = EX/MEM result, 2'b10 = MEM/WB result. 2'b11 is never driven.
- `stall`  out  1: hold PC and the IF/ID register.
- `id_ex_bubble`  out  1: load a NOP into the ID/EX register this cycle.
- `stall_cnt`  out  CNT_W: number of stall cycles since reset or clear.

## Operation
- Shadow slots EX, MEM and WB each hold {valid, rd, reg_write, mem_read}, plus rs1/rs2/use bits for EX.
- The shadow pipeline advances every cycle:
  - WB ← MEM; MEM ← EX.
  - EX ← ID fields, unless `stall` or `flush` is high. In that case EX ← invalid bubble.
- Load-use hazard (combinational, in ID): `stall` = 1 when all of the following hold:
  - EX.valid, EX.mem_read and EX.reg_write;
  - EX.rd ≠ 0;
  - (`id_use_rs1` and `id_rs1` == EX.rd) or (`id_use_rs2` and `id_rs2` == EX.rd).
- `stall` lasts exactly one cycle per load-use pair. On the next cycle the load is in MEM, and forwarding covers the dependency from WB one cycle later.
- `id_ex_bubble` = `stall` | `flush`.
- `flush` overrides `stall`: when `flush` = 1, `stall` = 0. The ID instruction is dead, so no hold is needed.
- Forwarding for operand A uses the EX slot's rs1 and use bit:
  - 2'b01 if MEM.valid & MEM.reg_write & MEM.rd ≠ 0 & MEM.rd == EX.rs1;
  - else 2'b10 on the same condition against WB;
  - else 2'b00.
- Operand B uses the same rule with rs2.
- MEM has priority over WB when both match.
- Register x0 is never forwarded.
- An unused source register (use bit = 0) always yields 2'b00.
- A load in MEM never produces a 2'b01 select. The stall guarantees this; an assertion checks it.
- Stall counter: increments by 1 on every cycle with `stall` = 1 and saturates at all-ones.
- `cnt_clear` takes priority over the increment.

## Timing
- Reset (`arst` asserted) clears all slot valid bits and `stall_cnt`. Consequently:
  - `fwd_a_sel` = `fwd_b_sel` = 2'b00;
  - `stall` = 0;
  - `id_ex_bubble` = 0.
- Reset is released synchronously by design convention. The first ID instruction is captured at the first rising edge after deassertion.
- Latency:
  - `stall`, `id_ex_bubble` and the select outputs are combinational from slot registers and ID inputs, valid in the same cycle.
  - `stall_cnt` updates one cycle after the stalled cycle.
- Reset mid-stall: all slots invalidate immediately and `stall` drops asynchronously.
- Simultaneous flush and load-use: no stall; bubble inserted; counter not incremented.
- Counter saturation: at 2^CNT_W−1, further stalls leave the value unchanged.

## Structure
- Shared pipeline package holds:
  - the forwarding select constants: FWD_RF = 2'b00, FWD_MEM = 2'b01, FWD_WB = 2'b10;
  - the slot struct/typedef {valid, rd, reg_write, mem_read}.
- One sub-module, `fwd_sel_unit`: purely combinational select logic for one operand. It is instantiated twice (A and B).
- Slot registers, hazard detection and the counter live in the top level.

## Test plan
- RAW distance 1: `add x5`, then `sub` using rs1 = x5 → `fwd_a_sel` = 2'b01 in the `sub` EX cycle, `stall` = 0.
- RAW distance 2 and double match: x5 written at distance 2 → `fwd_b_sel` = 2'b10. With x5 also written at distance 1 → 2'b01 (MEM priority).
- Load-use: `lw x7`, then `add` using rs2 = x7 → `stall` = 1 and `id_ex_bubble` = 1 for exactly one cycle; next EX cycle `fwd_b_sel` = 2'b10; `stall_cnt` = 1.
- x0 and unused operands: `addi x0` followed by a reader of x0 → selects 2'b00. With `id_use_rs2` = 0 and a matching rs2 → 2'b00.
- Flush during load-use: `flush` = 1 in the load-use cycle → `stall` = 0, `id_ex_bubble` = 1, `stall_cnt` unchanged.
- Reset and saturation:
  - assert `arst` mid-stall → all outputs 0 immediately;
  - with CNT_W = 2, five consecutive load-use pairs → `stall_cnt` = 3;
  - `cnt_clear` → 0.
